// File: rtl/fib_req_arbiter_pkg.sv
// Shared types and default sizing for the Fibonacci request arbiter.
// States, default widths and the per-job watchdog limit live here.
package fib_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int NTH_W_DEF   = 8;
  localparam int RES_W_DEF   = 20;
  localparam int TIMEOUT_DEF = 300;

endpackage

// File: rtl/fib_req_arbiter_if.sv
// Requester-side bundle: per-client request handshake plus the shared response bus.
// master = client side, slave = arbiter side.
interface fib_req_arbiter_if
  import fib_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int NTH_W = NTH_W_DEF,
  parameter int RES_W = RES_W_DEF
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*NTH_W-1:0] req_nth;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [RES_W-1:0]       rsp_result;
  logic                   rsp_err;

  modport master (
    output req_valid, req_nth,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_nth,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface

// File: rtl/fib_req_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Purely combinational; no state, no backpressure.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_req_arbiter.sv
// Shares one Fibonacci core among N_REQ clients, one job at a time, round-robin.
// Latency: grant T, start T+1, response one cycle after core done (or T+1 for nth=0).
// Backpressure: clients hold req_valid until a one-cycle req_ready; no grants outside IDLE.
module fib_req_arbiter
  import fib_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int NTH_W   = NTH_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fib_req_arbiter_if.slave     req_if,
  output logic                 core_start,
  output logic [NTH_W-1:0]     core_nth,
  input  logic [RES_W-1:0]     core_result,
  input  logic                 core_out_en,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] owner, rr_ptr;
  logic [TMR_W-1:0] timer;
  logic [N_REQ-1:0] gnt, owner_oh, rsp_valid_q;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [NTH_W-1:0] win_nth;
  logic             timed_out;
  logic [RES_W-1:0] rsp_result_q;
  logic             rsp_err_q;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req_if.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign win_nth   = req_if.req_nth[gnt_idx*NTH_W +: NTH_W];
  assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

  assign req_if.req_ready  = (state == IDLE) ? gnt : '0;
  assign req_if.rsp_valid  = rsp_valid_q;
  assign req_if.rsp_result = rsp_result_q;
  assign req_if.rsp_err    = rsp_err_q;

  // core_out_en is only looked at in WAIT: it can still be high from the last job during ISSUE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (gnt_any) state_d = (win_nth == '0) ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_out_en || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      timer        <= '0;
      core_nth     <= '0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state       <= state_d;
      core_start  <= (state_d == ISSUE);
      busy        <= (state_d != IDLE);
      rsp_valid_q <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          owner    <= gnt_idx;
          core_nth <= win_nth;
          rr_ptr   <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          if (win_nth == '0) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= gnt;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + TMR_W'(1);
          if (core_out_en) begin
            rsp_result_q <= core_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= owner_oh;
          end else if (timed_out) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= owner_oh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_req_arbiter.sv
// Directed bench for fib_req_arbiter with a behavioural Fibonacci core model.
// Core model raises out_en nth+2 cycles after start and holds it until the next start.
module tb_fib_req_arbiter;

  localparam int N  = 4;
  localparam int NW = 8;
  localparam int RW = 20;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          core_start;
  logic [NW-1:0] core_nth;
  logic [RW-1:0] core_result = '0;
  logic          core_out_en = 1'b0;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  int          cnt         = 0;
  logic [RW-1:0] res_m     = '0;
  bit          stale_hold  = 1'b0;
  bit          core_hang   = 1'b0;
  bit          clr_pending = 1'b0;

  always #5 clk = ~clk;

  fib_req_arbiter_if #(.N_REQ(N), .NTH_W(NW), .RES_W(RW)) rif ();

  fib_req_arbiter #(.N_REQ(N), .NTH_W(NW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_if      (rif),
    .core_start  (core_start),
    .core_nth    (core_nth),
    .core_result (core_result),
    .core_out_en (core_out_en),
    .busy        (busy)
  );

  function automatic logic [RW-1:0] fib(input logic [NW-1:0] n);
    logic [RW-1:0] a, b, t;
    a = '0;
    b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(negedge clk) begin
    if (core_start) begin
      cnt   = int'(core_nth) + 2;
      res_m = fib(core_nth);
      if (stale_hold) clr_pending = 1'b1;
      else            core_out_en = 1'b0;
    end else begin
      if (clr_pending) begin
        core_out_en = 1'b0;
        clr_pending = 1'b0;
      end
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0 && !core_hang) begin
          core_out_en = 1'b1;
          core_result = res_m;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int starts;

    reset_n       = 1'b0;
    rif.req_valid = '0;
    rif.req_nth   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid",  rif.rsp_valid,  0);
    chk("rst_req_ready",  rif.req_ready,  0);
    chk("rst_core_start", core_start,     0);
    chk("rst_busy",       busy,           0);
    chk("rst_rsp_err",    rif.rsp_err,    0);
    chk("rst_rsp_result", rif.rsp_result, 0);
    chk("rst_core_nth",   core_nth,       0);
    reset_n = 1'b1;
    tick;

    // single request, requester 2, nth = 1
    rif.req_nth[2*NW +: NW] = 8'd1;
    rif.req_valid = 4'b0100;
    #1;
    chk("single_ready_T", rif.req_ready, 4'b0100);
    tick;
    rif.req_valid = '0;
    chk("single_start_T1", core_start, 1);
    chk("single_nth_T1",   core_nth,   1);
    chk("single_busy_T1",  busy,       1);
    repeat (3) tick;
    chk("single_no_rsp_T4", rif.rsp_valid, 0);
    tick;
    chk("single_rsp_T5",    rif.rsp_valid,  4'b0100);
    chk("single_result_T5", rif.rsp_result, 20'h00001);
    chk("single_err_T5",    rif.rsp_err,    0);
    tick;
    chk("single_rsp_gone",  rif.rsp_valid, 0);
    chk("single_idle_busy", busy,          0);

    // reset pointer, then round-robin with all four clients continuously valid
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    rif.req_nth   = {8'd3, 8'd3, 8'd3, 8'd3};
    rif.req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      c = 0;
      while (rif.req_ready == '0 && c < 20) begin
        tick;
        c++;
      end
      chk("rr_grant", rif.req_ready, 32'd1 << (g % 4));
      starts = 0;
      c = 0;
      do begin
        tick;
        c++;
        if (core_start) starts++;
      end while (rif.rsp_valid == '0 && c < 20);
      chk("rr_rsp_owner", rif.rsp_valid,  32'd1 << (g % 4));
      chk("rr_result",    rif.rsp_result, 20'h00002);
      chk("rr_err",       rif.rsp_err,    0);
      chk("rr_one_start", starts,         1);
    end
    rif.req_valid = '0;
    tick;

    // nth = 0 rejected from requester 1
    rif.req_nth   = '0;
    rif.req_valid = 4'b0010;
    #1;
    chk("zero_ready_T", rif.req_ready, 4'b0010);
    tick;
    rif.req_valid = '0;
    chk("zero_rsp_T1",    rif.rsp_valid,  4'b0010);
    chk("zero_err_T1",    rif.rsp_err,    1);
    chk("zero_result_T1", rif.rsp_result, 0);
    chk("zero_no_start",  core_start,     0);
    tick;

    // stale out_en still high at ISSUE; real completion of nth = 8 lands later
    stale_hold = 1'b1;
    rif.req_nth[3*NW +: NW] = 8'd8;
    rif.req_valid = 4'b1000;
    #1;
    chk("stale_ready_T", rif.req_ready, 4'b1000);
    tick;
    rif.req_valid = '0;
    chk("stale_start_T1", core_start, 1);
    tick;
    chk("stale_no_rsp_T2", rif.rsp_valid, 0);
    repeat (9) tick;
    chk("stale_no_rsp_T11", rif.rsp_valid, 0);
    tick;
    chk("stale_rsp_T12",    rif.rsp_valid,  4'b1000);
    chk("stale_result_T12", rif.rsp_result, 20'h00015);
    chk("stale_err_T12",    rif.rsp_err,    0);
    stale_hold = 1'b0;
    tick;

    // timeout: core never completes
    core_hang = 1'b1;
    rif.req_nth[0 +: NW] = 8'd5;
    rif.req_valid = 4'b0001;
    #1;
    chk("to_ready_T", rif.req_ready, 4'b0001);
    tick;
    rif.req_valid = '0;
    repeat (300) tick;
    chk("to_no_rsp_T301", rif.rsp_valid, 0);
    tick;
    chk("to_rsp_T302",    rif.rsp_valid,  4'b0001);
    chk("to_err_T302",    rif.rsp_err,    1);
    chk("to_result_T302", rif.rsp_result, 0);
    tick;
    core_hang = 1'b0;
    rif.req_nth[1*NW +: NW] = 8'd1;
    rif.req_valid = 4'b0010;
    #1;
    chk("to_next_grant", rif.req_ready, 4'b0010);
    tick;
    rif.req_valid = '0;
    repeat (4) tick;
    chk("to_next_rsp",    rif.rsp_valid,  4'b0010);
    chk("to_next_result", rif.rsp_result, 20'h00001);
    tick;

    // reset in the middle of WAIT
    rif.req_nth[2*NW +: NW] = 8'd8;
    rif.req_valid = 4'b0100;
    #1;
    chk("mid_ready_T", rif.req_ready, 4'b0100);
    tick;
    rif.req_valid = '0;
    repeat (2) tick;
    chk("mid_busy_wait", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",   busy,           0);
    chk("mid_rst_start",  core_start,     0);
    chk("mid_rst_rsp",    rif.rsp_valid,  0);
    chk("mid_rst_nth",    core_nth,       0);
    chk("mid_rst_result", rif.rsp_result, 0);
    chk("mid_rst_err",    rif.rsp_err,    0);
    tick;
    reset_n = 1'b1;
    rif.req_nth[0 +: NW]    = 8'd1;
    rif.req_nth[3*NW +: NW] = 8'd1;
    rif.req_valid = 4'b1001;
    #1;
    chk("mid_after_grant", rif.req_ready, 4'b0001);
    tick;
    rif.req_valid = '0;
    repeat (4) tick;
    chk("mid_after_rsp", rif.rsp_valid, 4'b0001);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
